// File: rtl/rslatch_driver_if.sv
// Write-request handshake between clocked control logic and the RS latch driver.
// The master offers a one-bit value and the driver accepts it when ready.
interface rslatch_driver_if;
  logic req_valid;
  logic req_value;
  logic req_ready;

  modport master (
    output req_valid,
    output req_value,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_value,
    output req_ready
  );
endinterface

// File: rtl/rslatch_driver.sv
// Clocked driver for an asynchronous RS latch: width-controlled s/r pulse,
// then a synchronised readback of q/n that raises done and a sticky err.
module rslatch_driver #(
  parameter int PULSE_CYCLES  = 10,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  rslatch_driver_if.slave   req,
  input  logic              err_clr,
  input  logic              q,
  input  logic              n,
  output logic              s,
  output logic              r,
  output logic              done,
  output logic              err,
  output logic              stored
);

  localparam int MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ?
                        PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s_nxt, r_nxt;
  logic          stored_nxt, err_nxt;
  logic          q_meta, q_sync;
  logic          n_meta, n_sync;
  logic          fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      s      <= 1'b0;
      r      <= 1'b0;
      stored <= 1'b0;
      err    <= 1'b0;
      q_meta <= 1'b0;
      q_sync <= 1'b0;
      n_meta <= 1'b0;
      n_sync <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      s      <= s_nxt;
      r      <= r_nxt;
      stored <= stored_nxt;
      err    <= err_nxt;
      q_meta <= q;
      q_sync <= q_meta;
      n_meta <= n;
      n_sync <= n_meta;
    end
  end

  // Invalid latch state (q==n) counts as a failure as well.
  assign fail = (q_sync != stored) ||
                (n_sync == stored) ||
                (q_sync == n_sync);

  assign req.req_ready = (state == IDLE);
  assign done          = (state == CHECK);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    s_nxt      = 1'b0;
    r_nxt      = 1'b0;
    stored_nxt = stored;
    err_nxt    = err;
    if (err_clr) err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (req.req_valid) begin
          state_nxt  = DRIVE;
          cnt_nxt    = CW'(PULSE_CYCLES - 1);
          s_nxt      = req.req_value;
          r_nxt      = ~req.req_value;
          stored_nxt = req.req_value;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = CW'(SETTLE_CYCLES - 1);
        end else begin
          s_nxt   = stored;
          r_nxt   = ~stored;
          cnt_nxt = cnt - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = CHECK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (fail) err_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rslatch_driver.sv
// Directed bench for rslatch_driver with a behavioural RS latch attached
// and a fault switch that forces both latch outputs low.
module tb_rslatch_driver;
  logic clk;
  logic rst_n;
  logic err_clr;
  logic q, n;
  logic s, r;
  logic done, err, stored;
  logic lq;
  logic fault;

  int checks   = 0;
  int failures = 0;
  int s_hi, r_hi, s_rise, done_cnt, sr_both;
  logic s_prev;

  rslatch_driver_if req ();

  rslatch_driver #(
    .PULSE_CYCLES  (10),
    .SETTLE_CYCLES (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req.slave),
    .err_clr (err_clr),
    .q       (q),
    .n       (n),
    .s       (s),
    .r       (r),
    .done    (done),
    .err     (err),
    .stored  (stored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial lq = 1'b0;
  always @(s or r) begin
    if (s && !r) lq = 1'b1;
    else if (r && !s) lq = 1'b0;
  end
  assign q = fault ? 1'b0 : lq;
  assign n = fault ? 1'b0 : ~lq;

  always @(s or r) begin
    assert (!(s && r)) else $error("s and r both high");
  end

  always @(negedge clk) begin
    if (s) s_hi++;
    if (r) r_hi++;
    if (s && !s_prev) s_rise++;
    if (done) done_cnt++;
    if (s && r) sr_both++;
    s_prev = s;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    s_hi     = 0;
    r_hi     = 0;
    s_rise   = 0;
    done_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write: wait for ready, hold valid over the accepting edge,
  // then measure edges until done and check the pulse shape.
  task automatic write_chk(input logic v, input string tag);
    int lat;
    int w;
    w = 0;
    while (!req.req_ready && w < 40) begin
      tick();
      w++;
    end
    chk({tag, "_ready"}, 32'(req.req_ready), 32'd1);
    req.req_valid = 1'b1;
    req.req_value = v;
    clr_mon();
    tick();
    req.req_valid = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd13);
    tick();
    chk({tag, "_s_hi"}, 32'(s_hi), v ? 32'd10 : 32'd0);
    chk({tag, "_r_hi"}, 32'(r_hi), v ? 32'd0 : 32'd10);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_stored"}, 32'(stored), 32'(v));
  endtask

  initial begin
    int acc0, acc1, nacc, w;
    s_prev        = 1'b0;
    sr_both       = 0;
    clr_mon();
    fault         = 1'b0;
    err_clr       = 1'b0;
    req.req_valid = 1'b0;
    req.req_value = 1'b0;
    rst_n         = 1'b0;

    repeat (3) tick();
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_ready", 32'(req.req_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stored", 32'(stored), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(req.req_ready), 32'd1);
    chk("rel_err", 32'(err), 32'd0);

    write_chk(1'b1, "set");
    chk("set_q", 32'(q), 32'd1);
    chk("set_n", 32'(n), 32'd0);
    chk("set_err", 32'(err), 32'd0);

    write_chk(1'b0, "rst");
    chk("rstw_q", 32'(q), 32'd0);
    chk("rstw_n", 32'(n), 32'd1);
    chk("rstw_err", 32'(err), 32'd0);

    fault = 1'b1;
    write_chk(1'b1, "fault");
    chk("fault_err", 32'(err), 32'd1);
    fault = 1'b0;
    write_chk(1'b1, "good");
    chk("sticky_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 32'd0);

    // Valid held high: only ready observations are accepted.
    clr_mon();
    acc0 = -1;
    acc1 = -1;
    nacc = 0;
    req.req_valid = 1'b1;
    req.req_value = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (req.req_ready) begin
        if (nacc == 0) acc0 = i;
        else acc1 = i;
        nacc++;
      end
      tick();
    end
    req.req_valid = 1'b0;
    w = 0;
    while (!req.req_ready && w < 40) begin
      tick();
      w++;
    end
    tick();
    chk("busy_nacc", 32'(nacc), 32'd2);
    chk("busy_acc0", 32'(acc0), 32'd0);
    chk("busy_acc1", 32'(acc1), 32'd15);
    chk("busy_s_rise", 32'(s_rise), 32'd2);
    chk("busy_done", 32'(done_cnt), 32'd2);
    chk("busy_err", 32'(err), 32'd0);

    // Reset four cycles into a set pulse.
    req.req_valid = 1'b1;
    req.req_value = 1'b1;
    tick();
    req.req_valid = 1'b0;
    repeat (3) tick();
    clr_mon();
    chk("mid_s_before", 32'(s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_s_async", 32'(s), 32'd0);
    repeat (2) tick();
    chk("mid_stored", 32'(stored), 32'd0);
    chk("mid_ready", 32'(req.req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    write_chk(1'b0, "after");
    chk("after_q", 32'(q), 32'd0);
    chk("after_err", 32'(err), 32'd0);
    chk("sr_never_both", 32'(sr_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "bench timeout");
  end
endmodule
